// File: rtl/sample_capture.sv
// Sample acquisition: synchronizes the divided sample clock into strobes, stores ADC
// samples in a circular buffer and freezes a pre/post-trigger record for readout.
module sample_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic              slope_q, slope_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q;

  logic              tick_s;
  logic              in_busy_s;
  logic              hit_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] rd_idx_s;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state, pointer and trigger logic.
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], sample_clk};
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    pretrig_d    = pretrig_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    level_d      = level_q;
    slope_d      = slope_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    wr_en_s      = 1'b0;

    // sync_q[1] is the synchronized level; sync_q[2] is its previous value.
    tick_s    = sync_q[1] & ~sync_q[2];
    in_busy_s = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

    if (slope_q == 1'b0) begin
      hit_s = prev_valid_q && (prev_q < level_q) && (adc_data >= level_q);
    end else begin
      hit_s = prev_valid_q && (prev_q > level_q) && (adc_data <= level_q);
    end
    hit_s = hit_s || force_trig;

    if (arm) begin
      pretrig_d    = pretrig;
      level_d      = trig_level;
      slope_d      = trig_slope;
      triggered_d  = 1'b0;
      done_d       = 1'b0;
      prev_valid_d = 1'b0;
      pre_cnt_d    = pretrig;
      state_d      = (pretrig == {ADDR_W{1'b0}}) ? S_WAIT : S_PRE;
    end else if (tick_s && in_busy_s) begin
      wr_en_s      = 1'b1;
      wr_ptr_d     = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      prev_d       = adc_data;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE: begin
          pre_cnt_d = pre_cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
          if (pre_cnt_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          if (hit_s) begin
            triggered_d = 1'b1;
            start_ptr_d = wr_ptr_q - pretrig_q;
            post_cnt_d  = {ADDR_W{1'b1}} - pretrig_q;
            if (post_cnt_d == {ADDR_W{1'b0}}) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
          if (post_cnt_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_POST;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d   = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    rd_idx_s = start_ptr_q + rd_addr;
  end

  // Control and status registers.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 3'b000;
      wr_ptr_q     <= {ADDR_W{1'b0}};
      start_ptr_q  <= {ADDR_W{1'b0}};
      pre_cnt_q    <= {ADDR_W{1'b0}};
      post_cnt_q   <= {ADDR_W{1'b0}};
      pretrig_q    <= {ADDR_W{1'b0}};
      prev_q       <= {DATA_W{1'b0}};
      prev_valid_q <= 1'b0;
      level_q      <= {DATA_W{1'b0}};
      slope_q      <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      rd_data_q    <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      pretrig_q    <= pretrig_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      level_q      <= level_d;
      slope_q      <= slope_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      rd_data_q    <= mem[rd_idx_s];
    end
  end

  // Sample buffer write port; no reset so it maps onto RAM.
  always_ff @(posedge in_clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= adc_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_pos  = pretrig_q;

endmodule
